// File: rtl/psram_qpi_pkg.sv
// Shared opcodes, state encoding and defaults for the PSRAM QPI responder.
package psram_qpi_pkg;

  localparam logic [7:0] OP_RSTEN    = 8'h66;
  localparam logic [7:0] OP_RST      = 8'h99;
  localparam logic [7:0] OP_SPI2QPI  = 8'h35;
  localparam logic [7:0] OP_READ     = 8'hEB;
  localparam logic [7:0] OP_WRITE    = 8'h38;
  localparam logic [7:0] OP_EXIT_QPI = 8'hF5;

  localparam int unsigned WAIT_CYC_DEF = 7;
  localparam int unsigned ADDR_W_DEF   = 8;
  // Shared nibble/bit/wait counter; wide enough for WAIT_CYC up to 256.
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RDATA,
    S_IGNORE
  } state_e;

endpackage

// File: rtl/psram_qpi_responder_mem.sv
// Single-port synchronous word RAM with one-cycle read latency (BSRAM-inferable).
module psram_resp_mem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              mem_clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge mem_clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM-side SPI/QPI responder: reset/mode commands, quad read 0xEB, quad write 0x38.
// PSRAM_RESP_BURST_EN enables multi-word bursts with wrapping word index.
module psram_qpi_responder
  import psram_qpi_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic       mem_ce,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic [3:0] sio_oe,
  output logic       qpi_mode,
  output logic       busy,
  output logic       cmd_err
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         op_sr;
  logic [11:0]        wr_sr;
  logic [ADDR_W-1:0]  idx;
  logic [15:0]        rd_word;
  logic               is_write;
  logic               rsten_armed;

  logic [7:0]         op_next;
  logic               op_done;
  logic               mem_we;
  logic               mem_re;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_wdata;
  logic [15:0]        mem_rdata;

  // Opcode assembly and memory port control; RDATA prefetches the following word.
  always_comb begin
    op_next   = qpi_mode ? {op_sr[3:0], sio_in} : {op_sr, sio_in[0]};
    op_done   = qpi_mode ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(7));
    mem_wdata = {wr_sr, sio_in};
    mem_we    = !mem_ce && (state == S_WDATA) && (cnt == CNT_W'(3));
    mem_re    = !mem_ce && (cnt == '0) && ((state == S_WAIT) || (state == S_RDATA));
    mem_addr  = (state == S_RDATA) ? idx + ADDR_W'(1) : idx;
  end

  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .mem_clk (mem_clk),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

  // Transaction FSM, sampled on the rising edge.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_sr       <= '0;
      wr_sr       <= '0;
      idx         <= '0;
      rd_word     <= '0;
      is_write    <= 1'b0;
      rsten_armed <= 1'b0;
      qpi_mode    <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (mem_ce) begin
        state <= S_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          S_IDLE, S_CMD: begin
            op_sr <= op_next[6:0];
            cnt   <= cnt + CNT_W'(1);
            state <= S_CMD;
            if (op_done) begin
              cnt         <= '0;
              state       <= S_IGNORE;
              busy        <= 1'b0;
              rsten_armed <= 1'b0;
              case (op_next)
                OP_RSTEN:    rsten_armed <= 1'b1;
                OP_RST:      if (rsten_armed) qpi_mode <= 1'b0;
                OP_SPI2QPI:  if (!qpi_mode) qpi_mode <= 1'b1; else cmd_err <= 1'b1;
                OP_EXIT_QPI: if (qpi_mode) qpi_mode <= 1'b0; else cmd_err <= 1'b1;
                OP_READ, OP_WRITE: begin
                  if (qpi_mode) begin
                    state    <= S_ADDR;
                    busy     <= 1'b1;
                    is_write <= (op_next == OP_WRITE);
                  end else begin
                    cmd_err <= 1'b1;
                  end
                end
                default:     cmd_err <= 1'b1;
              endcase
            end
          end
          // Only the low ADDR_W bits of the 24-bit address survive the shift.
          S_ADDR: begin
            idx <= ADDR_W'({idx, sio_in});
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(5)) begin
              cnt   <= '0;
              state <= is_write ? S_WDATA : S_WAIT;
            end
          end
          S_WDATA: begin
            wr_sr <= mem_wdata[11:0];
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(3)) begin
              cnt <= '0;
`ifdef PSRAM_RESP_BURST_EN
              idx <= idx + ADDR_W'(1);
`else
              state <= S_IGNORE;
              busy  <= 1'b0;
`endif
            end
          end
          S_WAIT: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WAIT_CYC - 1)) begin
              cnt     <= '0;
              rd_word <= mem_rdata;
              state   <= S_RDATA;
            end
          end
          S_RDATA: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(3)) begin
              cnt <= '0;
`ifdef PSRAM_RESP_BURST_EN
              rd_word <= mem_rdata;
              idx     <= idx + ADDR_W'(1);
`else
              state <= S_IGNORE;
              busy  <= 1'b0;
`endif
            end
          end
          S_IGNORE: busy <= 1'b0;
          default: begin
            state <= S_IGNORE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read data is launched on the falling edge ahead of each sampling edge.
  always_ff @(negedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_out <= '0;
      sio_oe  <= '0;
    end else if (!mem_ce && (state == S_RDATA)) begin
      sio_oe <= 4'hF;
      case (cnt[1:0])
        2'd0:    sio_out <= rd_word[15:12];
        2'd1:    sio_out <= rd_word[11:8];
        2'd2:    sio_out <= rd_word[7:4];
        default: sio_out <= rd_word[3:0];
      endcase
    end else begin
      sio_out <= '0;
      sio_oe  <= '0;
    end
  end

endmodule
